// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Definitions shared by the matrix-multiply sequencer and the APB register file:
// the sequencer state encoding, the bit positions of the control-register fields,
// the register and scratchpad addresses, and a helper that checks a dimension
// field against the array size.
// -----------------------------------------------------------------------------
package matmul_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Control-register field positions. N, K and M are stored as dimension-1.
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_BANK_LSB  = 2;
  localparam int CTRL_N_LSB     = 8;
  localparam int CTRL_K_LSB     = 10;
  localparam int CTRL_M_LSB     = 12;
  localparam int CTRL_FIELD_W   = 2;

  // APB addresses used by the register file and the sequencer
  localparam logic [7:0] CTRL_REG_ADDR  = 8'h00;
  localparam logic [7:0] FLAGS_REG_ADDR = 8'h04;
  localparam logic [7:0] SP_BASE_ADDR   = 8'h40;

  // Bit positions in the FLAGS register
  localparam int FLAGS_DONE_BIT = 0;
  localparam int FLAGS_ERR_BIT  = 1;
  localparam int FLAGS_BUSY_BIT = 2;

  // A field holds dimension-1, so any field value >= max_dim names a dimension
  // the array cannot hold.
  function automatic logic dim_field_bad(input logic [CTRL_FIELD_W-1:0] field,
                                         input int unsigned max_dim);
    return ({{(32-CTRL_FIELD_W){1'b0}}, field} >= max_dim);
  endfunction

endpackage

// File: rtl/matmul_seq_counter.sv
// -----------------------------------------------------------------------------
// matmul_seq_counter
// Loadable up-counter with a terminal-count flag. The sequencer uses one
// instance for the k index, the drain wait and the n index.
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   load_i      load load_val_i on the next edge (takes priority over en_i)
//   en_i        increment on the next edge
//   load_val_i  value to load
//   term_i      terminal value
//   cnt_nxt_o   value the counter takes on the next edge
//   tc_o        the current count equals term_i
// -----------------------------------------------------------------------------
module matmul_seq_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load, increment or hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign tc_o      = (cnt_q == term_i);

endmodule

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
// Runs one matrix multiply for each START: it checks the dimension fields,
// streams K operand words into the PE array, waits for the array to drain, then
// writes N result rows into the selected scratchpad bank. It finishes with a
// DONE cycle that pulses done_o and the START clear.
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   ctrl_reg_i   control register ([0] START, [3:2] SP_BANK, [9:8] N-1,
//                [11:10] K-1, [13:12] M-1)
//   mem_rd_en_o  read enable for the A and B memories
//   mem_addr_o   A/B word index
//   pe_clear_o   clear the PE accumulators
//   pe_valid_o   read data is valid at the PE inputs
//   col_mask_o   active columns (bit j set when j < M)
//   res_row_o    selects the PE result row
//   sp_wr_en_o   scratchpad write enable
//   sp_addr_o    scratchpad word index
//   start_clr_o  one-cycle pulse telling the register file to clear START
//   busy_o       a run is in progress
//   done_o       one-cycle completion pulse
//   err_o        a dimension field was out of range; held until the next START
//                is accepted
// Each output register is loaded from the next state and the next count, so
// the outputs change on the same edge as the state.
// -----------------------------------------------------------------------------
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int PIPE_LAT   = 2,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int ROW_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [15:0]           ctrl_reg_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  pe_clear_o,
  output logic                  pe_valid_o,
  output logic [MAX_DIM-1:0]    col_mask_o,
  output logic [ROW_W-1:0]      res_row_o,
  output logic                  sp_wr_en_o,
  output logic [ADDR_WIDTH-1:0] sp_addr_o,
  output logic                  start_clr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // The counter must hold any legal dimension index and the drain count PIPE_LAT.
  localparam int CNT_DIM_W = $clog2(MAX_DIM) + 1;
  localparam int CNT_PL_W  = $clog2(PIPE_LAT + 1);
  localparam int CNT_W     = (CNT_DIM_W > CNT_PL_W) ? CNT_DIM_W : CNT_PL_W;

  state_e state_q, state_d;

  // Fields latched when START is accepted
  logic [CTRL_FIELD_W-1:0] n_m1_q, n_m1_d;
  logic [CTRL_FIELD_W-1:0] k_m1_q, k_m1_d;
  logic [CTRL_FIELD_W-1:0] m_m1_q, m_m1_d;
  logic [CTRL_FIELD_W-1:0] bank_q, bank_d;
  logic                    err_q,  err_d;

  // Output registers
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic                  pe_clear_q,  pe_clear_d;
  logic                  pe_valid_q,  pe_valid_d;
  logic [MAX_DIM-1:0]    col_mask_q,  col_mask_d;
  logic [ROW_W-1:0]      res_row_q,   res_row_d;
  logic                  sp_wr_en_q,  sp_wr_en_d;
  logic [ADDR_WIDTH-1:0] sp_addr_q,   sp_addr_d;
  logic                  start_clr_q, start_clr_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;

  // Shared counter
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_tc;

  // Control-register decode
  logic                    start;
  logic [CTRL_FIELD_W-1:0] fld_n, fld_k, fld_m, fld_bank;
  logic                    dim_bad;
  logic                    ctrl_unused;

  assign start    = ctrl_reg_i[CTRL_START_BIT];
  assign fld_bank = ctrl_reg_i[CTRL_BANK_LSB +: CTRL_FIELD_W];
  assign fld_n    = ctrl_reg_i[CTRL_N_LSB    +: CTRL_FIELD_W];
  assign fld_k    = ctrl_reg_i[CTRL_K_LSB    +: CTRL_FIELD_W];
  assign fld_m    = ctrl_reg_i[CTRL_M_LSB    +: CTRL_FIELD_W];
  assign dim_bad  = dim_field_bad(fld_n, MAX_DIM) | dim_field_bad(fld_k, MAX_DIM) |
                    dim_field_bad(fld_m, MAX_DIM);
  // Reserved control bits are not used by the sequencer
  assign ctrl_unused = ^{ctrl_reg_i[15:14], ctrl_reg_i[7:4], ctrl_reg_i[1]};

  // Terminal count for the current phase
  always_comb begin
    cnt_term = {CNT_W{1'b0}};
    case (state_q)
      ST_LOAD:  cnt_term = CNT_W'(k_m1_q);
      ST_DRAIN: cnt_term = CNT_W'(PIPE_LAT);
      ST_WRITE: cnt_term = CNT_W'(n_m1_q);
      default:  cnt_term = {CNT_W{1'b0}};
    endcase
  end

  // Restart the counter at 0 on every state change and while idle
  assign cnt_load = (state_d != state_q) || (state_q == ST_IDLE);

  matmul_seq_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .en_i       (1'b1),
    .load_val_i ({CNT_W{1'b0}}),
    .term_i     (cnt_term),
    .cnt_nxt_o  (cnt_nxt),
    .tc_o       (cnt_tc)
  );

  // Next state, field latching and the sticky error flag
  always_comb begin
    state_d = state_q;
    n_m1_d  = n_m1_q;
    k_m1_d  = k_m1_q;
    m_m1_d  = m_m1_q;
    bank_d  = bank_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_m1_d = fld_n;
          k_m1_d = fld_k;
          m_m1_d = fld_m;
          bank_d = fld_bank;
          if (dim_bad) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_tc) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_tc) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_WRITE: begin
        if (cnt_tc) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, from the next state and the next count
  always_comb begin
    mem_rd_en_d = 1'b0;
    mem_addr_d  = {ADDR_WIDTH{1'b0}};
    pe_clear_d  = 1'b0;
    res_row_d   = {ROW_W{1'b0}};
    sp_wr_en_d  = 1'b0;
    sp_addr_d   = {ADDR_WIDTH{1'b0}};
    start_clr_d = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    col_mask_d  = {MAX_DIM{1'b0}};
    case (state_d)
      ST_LOAD: begin
        mem_rd_en_d = 1'b1;
        mem_addr_d  = ADDR_WIDTH'(cnt_nxt);
        pe_clear_d  = (cnt_nxt == {CNT_W{1'b0}});
      end
      ST_WRITE: begin
        sp_wr_en_d = 1'b1;
        res_row_d  = cnt_nxt[ROW_W-1:0];
        sp_addr_d  = ADDR_WIDTH'(bank_d) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(cnt_nxt);
      end
      ST_DONE: begin
        start_clr_d = 1'b1;
        done_d      = 1'b1;
      end
      default: begin
        mem_rd_en_d = 1'b0;
      end
    endcase
    for (int j = 0; j < MAX_DIM; j++) begin
      col_mask_d[j] = busy_d & (j <= int'(m_m1_d));
    end
  end

  // Read data reaches the PE inputs one cycle after the read is issued
  assign pe_valid_d = mem_rd_en_q;

  // State and latched fields
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      n_m1_q  <= {CTRL_FIELD_W{1'b0}};
      k_m1_q  <= {CTRL_FIELD_W{1'b0}};
      m_m1_q  <= {CTRL_FIELD_W{1'b0}};
      bank_q  <= {CTRL_FIELD_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_m1_q  <= n_m1_d;
      k_m1_q  <= k_m1_d;
      m_m1_q  <= m_m1_d;
      bank_q  <= bank_d;
      err_q   <= err_d;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      pe_clear_q  <= 1'b0;
      pe_valid_q  <= 1'b0;
      col_mask_q  <= {MAX_DIM{1'b0}};
      res_row_q   <= {ROW_W{1'b0}};
      sp_wr_en_q  <= 1'b0;
      sp_addr_q   <= {ADDR_WIDTH{1'b0}};
      start_clr_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      pe_clear_q  <= pe_clear_d;
      pe_valid_q  <= pe_valid_d;
      col_mask_q  <= col_mask_d;
      res_row_q   <= res_row_d;
      sp_wr_en_q  <= sp_wr_en_d;
      sp_addr_q   <= sp_addr_d;
      start_clr_q <= start_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_en_o = mem_rd_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign pe_clear_o  = pe_clear_q;
  assign pe_valid_o  = pe_valid_q;
  assign col_mask_o  = col_mask_q;
  assign res_row_o   = res_row_q;
  assign sp_wr_en_o  = sp_wr_en_q;
  assign sp_addr_o   = sp_addr_q;
  assign start_clr_o = start_clr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
// Directed runs of the sequencer. Each run pushes its expected timeline
// parameters into a queue. An independent monitor pops a run when that run's
// first cycle arrives and compares every output on every falling edge.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

  localparam int PL = 2;

  logic        clk;
  logic        rst_ni;
  logic [15:0] ctrl_reg_i;
  logic        mem_rd_en_o;
  logic [4:0]  mem_addr_o;
  logic        pe_clear_o;
  logic        pe_valid_o;
  logic [1:0]  col_mask_o;
  logic [0:0]  res_row_o;
  logic        sp_wr_en_o;
  logic [4:0]  sp_addr_o;
  logic        start_clr_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  matmul_sequencer #(
    .DATA_WIDTH(32),
    .BUS_WIDTH (64),
    .ADDR_WIDTH(5),
    .PIPE_LAT  (PL)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .ctrl_reg_i (ctrl_reg_i),
    .mem_rd_en_o(mem_rd_en_o),
    .mem_addr_o (mem_addr_o),
    .pe_clear_o (pe_clear_o),
    .pe_valid_o (pe_valid_o),
    .col_mask_o (col_mask_o),
    .res_row_o  (res_row_o),
    .sp_wr_en_o (sp_wr_en_o),
    .sp_addr_o  (sp_addr_o),
    .start_clr_o(start_clr_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  // One expected run. len and sp_base are worked out by hand in the vector table.
  typedef struct {
    int         start;    // value of cyc in the run's first busy cycle
    int         n;
    int         k;
    logic       err;
    logic [1:0] mask;
    int         len;      // number of busy cycles
    int         sp_base;  // SP_BANK*2
  } run_t;

  run_t exp_q[$];
  run_t cur;
  bit   active;
  logic sticky_err;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [20:0] all_outs;
  assign all_outs = {mem_rd_en_o, mem_addr_o, pe_clear_o, pe_valid_o, col_mask_o, res_row_o,
                     sp_wr_en_o, sp_addr_o, start_clr_o, busy_o, done_o, err_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int start, input int n, input int k, input logic err,
                          input logic [1:0] mask, input int len, input int sp_base);
    run_t r;
    r.start = start; r.n = n; r.k = k; r.err = err;
    r.mask = mask; r.len = len; r.sp_base = sp_base;
    exp_q.push_back(r);
  endtask

  // Called at a falling edge: START is sampled on the next rising edge
  task automatic start_run(input logic [15:0] ctrl, input int n, input int k, input logic err,
                           input logic [1:0] mask, input int len, input int sp_base);
    ctrl_reg_i = ctrl;
    push_exp(cyc + 1, n, k, err, mask, len, sp_base);
  endtask

  // Acts as the register file: clears START once the sequencer asks for it
  task automatic wait_clr();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (start_clr_o) seen = 1'b1;
    end
    if (seen) ctrl_reg_i[0] = 1'b0;
    check("start_clr within budget", 32'(seen), 32'd1);
  endtask

  // Monitor: reference timeline for every cycle
  always @(negedge clk) begin
    int rel;
    int w0;
    logic e_busy, e_rd, e_clr, e_pev, e_wr, e_done, e_err;
    logic [4:0] e_addr, e_sp;
    logic [0:0] e_row;
    logic [1:0] e_mask;
    e_busy = 1'b0; e_rd = 1'b0; e_clr = 1'b0; e_pev = 1'b0; e_wr = 1'b0;
    e_done = 1'b0; e_addr = 5'd0; e_sp = 5'd0; e_row = 1'b0; e_mask = 2'b00;
    if (!rst_ni) begin
      active = 1'b0;
      sticky_err = 1'b0;
      e_err = 1'b0;
    end else begin
      if (active && (cyc - cur.start + 1) > cur.len) begin
        active = 1'b0;
        sticky_err = cur.err;
      end
      if (!active && exp_q.size() > 0 && exp_q[0].start == cyc) begin
        cur = exp_q.pop_front();
        active = 1'b1;
      end
      e_err = sticky_err;
      if (active) begin
        rel    = cyc - cur.start + 1;
        w0     = cur.k + 2 + PL;
        e_busy = 1'b1;
        e_err  = cur.err;
        e_mask = cur.mask;
        e_done = (rel == cur.len);
        if (!cur.err) begin
          e_rd  = (rel <= cur.k);
          e_clr = (rel == 1);
          if (e_rd) e_addr = 5'(rel - 1);
          e_pev = (rel >= 2) && (rel <= cur.k + 1);
          e_wr  = (rel >= w0) && (rel < w0 + cur.n);
          if (e_wr) begin
            e_row = 1'(rel - w0);
            e_sp  = 5'(cur.sp_base + rel - w0);
          end
        end
      end
    end
    check("busy_o",      32'(busy_o),      32'(e_busy));
    check("mem_rd_en_o", 32'(mem_rd_en_o), 32'(e_rd));
    check("mem_addr_o",  32'(mem_addr_o),  32'(e_addr));
    check("pe_clear_o",  32'(pe_clear_o),  32'(e_clr));
    check("pe_valid_o",  32'(pe_valid_o),  32'(e_pev));
    check("sp_wr_en_o",  32'(sp_wr_en_o),  32'(e_wr));
    check("sp_addr_o",   32'(sp_addr_o),   32'(e_sp));
    check("res_row_o",   32'(res_row_o),   32'(e_row));
    check("done_o",      32'(done_o),      32'(e_done));
    check("start_clr_o", 32'(start_clr_o), 32'(e_done));
    check("col_mask_o",  32'(col_mask_o),  32'(e_mask));
    check("err_o",       32'(err_o),       32'(e_err));
  end

  initial begin
    #100000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c0;
    rst_ni = 1'b1;
    ctrl_reg_i = 16'h0000;
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'(all_outs), 32'd0);
    #1 rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // N=K=M=2, bank 1: writes at 2,3, done in cycle 8
    start_run(16'h1505, 2, 2, 1'b0, 2'b11, 8, 2);
    wait_clr();
    repeat (2) @(negedge clk);

    // N=1, K=2, M=1, bank 2: one write at 4, mask 01
    start_run(16'h0409, 1, 2, 1'b0, 2'b01, 7, 4);
    wait_clr();
    repeat (2) @(negedge clk);

    // N field 2 (dimension 3): error, single busy/done cycle
    start_run(16'h0201, 3, 1, 1'b1, 2'b01, 1, 0);
    wait_clr();
    // START in the idle cycle after DONE: N=2, K=1, M=2, bank 3, clears err
    @(negedge clk);
    start_run(16'h110D, 2, 1, 1'b0, 2'b11, 7, 6);
    wait_clr();
    repeat (2) @(negedge clk);

    // Reset in the first WRITE cycle of an N=K=M=2 run
    start_run(16'h1505, 2, 2, 1'b0, 2'b11, 8, 2);
    repeat (6) @(negedge clk);
    #1 rst_ni = 1'b0;
    ctrl_reg_i = 16'h0000;
    #1 check("async reset mid-run", 32'(all_outs), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_ni = 1'b1;
    repeat (5) @(negedge clk);

    // START held high with the clear ignored: second run begins after one idle cycle
    c0 = cyc;
    start_run(16'h0409, 1, 2, 1'b0, 2'b01, 7, 4);
    push_exp(c0 + 9, 1, 2, 1'b0, 2'b01, 7, 4);
    repeat (11) @(negedge clk);
    ctrl_reg_i = 16'h0000;
    wait_clr();
    repeat (5) @(negedge clk);

    check("all expected runs started", 32'(exp_q.size()), 32'd0);
    check("no run left open", 32'(active), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control sequencer for the matrix-multiply accelerator, sitting between the APB register file and the operand memories, PE array and scratchpad banks. On a set START bit in the control register it validates the dimension fields, streams K operand words from the A/B memories into the PE array, drains the array, and writes the N result rows into the selected scratchpad bank. On completion it pulses a clear for START, which frees the APB slave again, and reports done/error for the flags register.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one matrix element
- BUS_WIDTH, 64, width of one memory word
- ADDR_WIDTH, 5, operand/scratchpad word-index width
- PIPE_LAT, 2, PE-array accumulate latency in cycles (≥1)
- MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, max N/K/M

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- ctrl_reg_i  in  16  control register: [0] START, [3:2] SP_BANK, [9:8] N-1, [11:10] K-1, [13:12] M-1
- mem_rd_en_o  out  1  A and B memory read enable
- mem_addr_o  out  ADDR_WIDTH  A/B word index k
- pe_clear_o  out  1  zero PE accumulators
- pe_valid_o  out  1  A/B read data valid at PE inputs
- col_mask_o  out  MAX_DIM  bit j set iff j < M
- res_row_o  out  $clog2(MAX_DIM) (min 1)  PE result row select
- sp_wr_en_o  out  1  scratchpad write enable
- sp_addr_o  out  ADDR_WIDTH  scratchpad word index = SP_BANK*MAX_DIM + n
- start_clr_o  out  1  one-cycle pulse: clear START in register file
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  dimension error, sticky until next accepted START

## Operation
- States: IDLE, LOAD, DRAIN, WRITE, DONE.
- IDLE: samples ctrl_reg_i. START=1 → latch N, K, M, SP_BANK. If any dim field ≥ MAX_DIM → err next = 1, go to DONE. Otherwise err next = 0, go to LOAD.
- LOAD: k = 0..K-1, one per cycle. mem_rd_en_o=1, mem_addr_o=k. pe_clear_o=1 only when k=0. After k=K-1 → DRAIN.
- pe_valid_o = mem_rd_en_o delayed one cycle. Memory read latency is 1.
- DRAIN: 1+PIPE_LAT cycles. Covers the final read plus array latency. Then → WRITE.
- WRITE: n = 0..N-1, one per cycle. sp_wr_en_o=1, res_row_o=n, sp_addr_o = SP_BANK*MAX_DIM+n. After n=N-1 → DONE.
- DONE: exactly one cycle. start_clr_o=1 and done_o=1. Then → IDLE.
- The register file clears START on the DONE edge, so IDLE never restarts on a stale START.
- busy_o=1 in every state except IDLE.
- col_mask_o is driven from the latched M while busy, and is 0 in IDLE.
- ctrl_reg_i is ignored outside IDLE.
- Outputs not listed as active in a state are 0 in that state.
- Counters are sized to $clog2(MAX_DIM)+1 and never wrap during a legal run.

## Timing
- Reset (async, immediate) puts the block in IDLE. All outputs are 0, err_o is 0, and latched fields are 0.
- Reset mid-operation aborts with no further reads or writes and no done_o pulse.
- Let cycle 0 be the edge on which IDLE samples START=1.
  - LOAD occupies cycles 1..K.
  - pe_valid_o is high in cycles 2..K+1.
  - DRAIN occupies cycles K+1..K+1+PIPE_LAT.
  - WRITE occupies the next N cycles.
  - DONE follows WRITE.
- busy_o is high for K+1+PIPE_LAT+N+1 cycles.
- Error path: busy_o is high for 1 cycle (DONE only), done_o=1 and err_o=1 in that cycle. No mem or sp activity.
- START held high across completion does not retrigger, because the register file has cleared it.
- A new START sampled in the IDLE cycle after DONE is accepted normally.

## Structure
- Shared package matmul_pkg holds:
  - state encoding constants;
  - control-register field offsets (START, SP_BANK, N, K, M);
  - control-register address and FLAGS/SP address constants, shared with the APB slave.
- One sub-module, matmul_seq_counter: a loadable up-counter with terminal-count output. Instantiated once and reused for k (LOAD), drain, and n (WRITE).

## Test plan
- N=K=M=2, SP_BANK=1, PIPE_LAT=2 → mem_addr_o 0,1 with rd_en; pe_clear_o in cycle 1 only; sp_addr_o 2,3 with res_row_o 0,1; done_o and start_clr_o together in cycle 8; busy_o high cycles 1–8.
- N=1, K=2, M=1 → col_mask_o=01; exactly one sp write at sp_addr_o = SP_BANK*2.
- N field = 2 (dim 3 > MAX_DIM) → err_o=1, single-cycle busy/done, zero mem_rd_en_o and sp_wr_en_o; next valid START clears err_o.
- rst_ni low during WRITE → all outputs 0 asynchronously; after release, no done_o until a new START.
- START held at 1 externally (clear ignored) → sequencer restarts only from IDLE; with clear honoured, exactly one run per START write.
- Back-to-back runs: second START applied in the IDLE cycle after DONE → LOAD begins the next cycle with the new dims latched.
